// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared single-port SRAM arbiter for instruction and data requesters
//
// Purpose: grants one of two requesters (fetch, load/store) onto a single SRAM
// port each cycle. Data wins by default, but after MAX_DATA_RUN consecutive data
// grants with a fetch waiting, the fetch is forced through. Read data returns one
// cycle after issue and is routed to whichever requester issued the read.
//
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   inst_req/inst_addr               fetch request and address
//   inst_stall/inst_rvalid/inst_rdata fetch stall, return pulse, held return data
//   data_req/data_wen/data_addr/data_wdata  load/store request
//   data_stall/data_rvalid/data_rdata       load/store stall, return pulse, held data
//   mem_en/mem_wen/mem_addr/mem_wdata       shared SRAM command
//   mem_rdata                                SRAM read data (one cycle after issue)

module mem_arbiter #(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_stall,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_stall,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,

  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [3:0] MaxRun = MAX_DATA_RUN[3:0];

  logic [3:0]  run_cnt_q, run_cnt_d;
  owner_e      owner_q, owner_d;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  logic run_full;
  logic inst_grant;
  logic data_grant;

  // Grant decode. The fetch only preempts data once the run counter has
  // saturated; otherwise it wins only when data is idle.
  always_comb begin
    run_full   = (run_cnt_q == MaxRun);
    inst_grant = resetn & inst_req & (~data_req | run_full);
    data_grant = resetn & data_req & ~inst_grant;
  end

  // Shared SRAM command mux; idle port drives all zeros.
  always_comb begin
    mem_en    = inst_grant | data_grant;
    mem_wen   = 4'b0000;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (inst_grant) begin
      mem_addr = inst_addr;
    end else if (data_grant) begin
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  always_comb begin
    inst_stall = resetn & inst_req & ~inst_grant;
    data_stall = resetn & data_req & ~data_grant;
  end

  // Run counter only tracks data grants that actually block a waiting fetch.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (inst_grant || !inst_req) begin
      run_cnt_d = 4'd0;
    end else if (data_grant && !run_full) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
  end

  // Stores complete in their grant cycle, so only reads record an owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (inst_grant) begin
      owner_d = OWN_INST;
    end else if (data_grant && (data_wen == 4'b0000)) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_cnt_q    <= 4'd0;
      owner_q      <= OWN_NONE;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
    end else begin
      run_cnt_q <= run_cnt_d;
      owner_q   <= owner_d;
      if (owner_q == OWN_INST) inst_rdata_q <= mem_rdata;
      if (owner_q == OWN_DATA) data_rdata_q <= mem_rdata;
    end
  end

  // The return cycle shows mem_rdata directly so data is visible with the
  // pulse; the _q copies hold it afterwards. Gating with resetn drops a
  // response whose return cycle coincides with reset.
  always_comb begin
    inst_rvalid = resetn & (owner_q == OWN_INST);
    data_rvalid = resetn & (owner_q == OWN_DATA);
    inst_rdata  = 32'h0;
    data_rdata  = 32'h0;
    if (resetn) begin
      inst_rdata = inst_rvalid ? mem_rdata : inst_rdata_q;
      data_rdata = data_rvalid ? mem_rdata : data_rdata_q;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter

module tb_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_stall;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_stall;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_stall(inst_stall),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_stall(data_stall),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Inputs change at the falling edge; checks happen 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [3:0] cnt_before [6];
    logic       exp_inst;
    cnt_before = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1;
    inst_addr = 32'h0; data_addr = 32'h0; data_wen = 4'h0;
    data_wdata = 32'h0; mem_rdata = 32'h0;

    // Reset: requests present but ignored
    cyc(); settle();
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_inst_stall", {31'h0, inst_stall}, 32'h0);
    chk("rst_data_stall", {31'h0, data_stall}, 32'h0);
    cyc(); settle();
    chk("rst_inst_rvalid", {31'h0, inst_rvalid}, 32'h0);
    chk("rst_data_rvalid", {31'h0, data_rvalid}, 32'h0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    chk("rst_data_rdata", data_rdata, 32'h0);
    chk("rst_run_cnt", {28'h0, dut.run_cnt_q}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // Single fetch
    cyc(); resetn = 1'b1; inst_req = 1'b1; data_req = 1'b0; inst_addr = 32'hBFC0_0000; settle();
    chk("f_mem_en", {31'h0, mem_en}, 32'h1);
    chk("f_mem_wen", {28'h0, mem_wen}, 32'h0);
    chk("f_mem_addr", mem_addr, 32'hBFC0_0000);
    chk("f_mem_wdata", mem_wdata, 32'h0);
    chk("f_inst_stall", {31'h0, inst_stall}, 32'h0);
    cyc(); inst_req = 1'b0; mem_rdata = 32'h2401_0001; settle();
    chk("f_inst_rvalid", {31'h0, inst_rvalid}, 32'h1);
    chk("f_inst_rdata", inst_rdata, 32'h2401_0001);
    chk("f_data_rvalid", {31'h0, data_rvalid}, 32'h0);
    chk("f_inst_stall2", {31'h0, inst_stall}, 32'h0);
    chk("f_idle_mem_en", {31'h0, mem_en}, 32'h0);
    chk("f_idle_addr", mem_addr, 32'h0);
    cyc(); mem_rdata = 32'h5A5A_5A5A; settle();
    chk("f_rvalid_drop", {31'h0, inst_rvalid}, 32'h0);
    chk("f_rdata_hold", inst_rdata, 32'h2401_0001);

    // Simultaneous requests: data wins, fetch follows
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0004; data_req = 1'b1;
    data_wen = 4'h0; data_addr = 32'h8000_1000; mem_rdata = 32'h0; settle();
    chk("b_mem_addr", mem_addr, 32'h8000_1000);
    chk("b_inst_stall", {31'h0, inst_stall}, 32'h1);
    chk("b_data_stall", {31'h0, data_stall}, 32'h0);
    cyc(); data_req = 1'b0; mem_rdata = 32'h1111_2222; settle();
    chk("b_data_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("b_data_rdata", data_rdata, 32'h1111_2222);
    chk("b_inst_grant_addr", mem_addr, 32'hBFC0_0004);
    chk("b_inst_stall2", {31'h0, inst_stall}, 32'h0);
    chk("b_run_cnt", {28'h0, dut.run_cnt_q}, 32'h1);
    cyc(); inst_req = 1'b0; mem_rdata = 32'h3333_4444; settle();
    chk("b_inst_rvalid", {31'h0, inst_rvalid}, 32'h1);
    chk("b_inst_rdata", inst_rdata, 32'h3333_4444);
    chk("b_data_rvalid0", {31'h0, data_rvalid}, 32'h0);
    chk("b_data_rdata_hold", data_rdata, 32'h1111_2222);

    // Fairness: both held for six cycles -> D,D,D,D,I,D
    for (int i = 0; i < 6; i++) begin
      cyc();
      inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'hC000_0000;
      data_addr = 32'h8000_3000 + 32'(i * 4); data_wen = 4'h0;
      mem_rdata = 32'hA000_0000 + 32'(i);
      settle();
      exp_inst = (i == 4);
      chk("r_data_stall", {31'h0, data_stall}, {31'h0, exp_inst});
      chk("r_inst_stall", {31'h0, inst_stall}, {31'h0, ~exp_inst});
      chk("r_mem_addr", mem_addr, exp_inst ? 32'hC000_0000 : 32'h8000_3000 + 32'(i * 4));
      chk("r_run_cnt", {28'h0, dut.run_cnt_q}, {28'h0, cnt_before[i]});
      if (i == 5) begin
        chk("r_inst_rvalid", {31'h0, inst_rvalid}, 32'h1);
        chk("r_inst_rdata", inst_rdata, 32'hA000_0005);
      end else if (i > 0) begin
        chk("r_data_rvalid", {31'h0, data_rvalid}, 32'h1);
        chk("r_data_rdata", data_rdata, 32'hA000_0000 + 32'(i));
      end
    end
    cyc(); inst_req = 1'b0; data_req = 1'b0; mem_rdata = 32'hA000_0006; settle();
    chk("r_last_rvalid", {31'h0, data_rvalid}, 32'h1);
    chk("r_last_rdata", data_rdata, 32'hA000_0006);
    chk("r_final_cnt", {28'h0, dut.run_cnt_q}, 32'h1);
    chk("r_inst_hold", inst_rdata, 32'hA000_0005);

    // Store: one cycle, no return
    cyc(); data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h8000_0010;
    data_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h0; settle();
    chk("s_mem_en", {31'h0, mem_en}, 32'h1);
    chk("s_mem_wen", {28'h0, mem_wen}, 32'h3);
    chk("s_mem_addr", mem_addr, 32'h8000_0010);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_data_stall", {31'h0, data_stall}, 32'h0);
    cyc(); data_req = 1'b0; data_wen = 4'h0; data_wdata = 32'h0; mem_rdata = 32'h5555_5555; settle();
    chk("s_no_rvalid", {31'h0, data_rvalid}, 32'h0);
    chk("s_rdata_hold", data_rdata, 32'hA000_0006);

    // Load followed by reset: response discarded
    cyc(); data_req = 1'b1; data_addr = 32'h8000_2000; mem_rdata = 32'h0; settle();
    chk("x_mem_en", {31'h0, mem_en}, 32'h1);
    chk("x_mem_addr", mem_addr, 32'h8000_2000);
    cyc(); resetn = 1'b0; inst_req = 1'b1; mem_rdata = 32'h6666_6666; settle();
    chk("x_rvalid", {31'h0, data_rvalid}, 32'h0);
    chk("x_rdata", data_rdata, 32'h0);
    chk("x_mem_en_rst", {31'h0, mem_en}, 32'h0);
    chk("x_data_stall", {31'h0, data_stall}, 32'h0);
    chk("x_inst_stall", {31'h0, inst_stall}, 32'h0);
    cyc(); resetn = 1'b1; inst_req = 1'b0; data_req = 1'b0; settle();
    chk("x_run_cnt", {28'h0, dut.run_cnt_q}, 32'h0);
    chk("x_rvalid_post", {31'h0, data_rvalid}, 32'h0);
    chk("x_rdata_post", data_rdata, 32'h0);
    chk("x_inst_rdata_post", inst_rdata, 32'h0);

    // Alternating fetch/load every cycle: routing with 1-cycle latency
    for (int k = 0; k < 7; k++) begin
      cyc();
      inst_req  = (k < 6) && (k % 2 == 0);
      data_req  = (k < 6) && (k % 2 == 1);
      inst_addr = 32'h0000_1000 + 32'(k);
      data_addr = 32'h8000_4000 + 32'(k);
      data_wen  = 4'h0;
      mem_rdata = 32'hB000_0000 + 32'(k);
      settle();
      if (k < 6) begin
        chk("a_mem_addr", mem_addr, (k % 2 == 0) ? 32'h0000_1000 + 32'(k) : 32'h8000_4000 + 32'(k));
      end
      if (k > 0) begin
        if ((k - 1) % 2 == 0) begin
          chk("a_inst_rvalid", {31'h0, inst_rvalid}, 32'h1);
          chk("a_data_rvalid", {31'h0, data_rvalid}, 32'h0);
          chk("a_inst_rdata", inst_rdata, 32'hB000_0000 + 32'(k));
        end else begin
          chk("a_data_rvalid", {31'h0, data_rvalid}, 32'h1);
          chk("a_inst_rvalid", {31'h0, inst_rvalid}, 32'h0);
          chk("a_data_rdata", data_rdata, 32'hB000_0000 + 32'(k));
        end
      end
    end
    cyc(); inst_req = 1'b0; data_req = 1'b0; mem_rdata = 32'hFFFF_FFFF; settle();
    chk("a_inst_hold", inst_rdata, 32'hB000_0005);
    chk("a_data_hold", data_rdata, 32'hB000_0006);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
